pam8_rx_slicer: RTL and testbench

Receive-side counterpart of the 8-PAM x4-upsampled pulse-shaping transmit chain. Takes the 16-bit shaped/filtered sample stream at 4 samples per symbol and acquires the best sampling phase by per-phase energy accumulation. After acquisition it decimates by 4 at that phase and slices each sample into an 8-PAM decision. It sits after the receive filter and feeds symbol-error checking in the FIR bench.

---
 rtl/pam8_pkg.sv | 28 ++
 rtl/pam8_slicer.sv | 40 ++++
 rtl/pam8_rx_slicer.sv | 138 +++++++++++++
 tb/tb_pam8_rx_slicer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pam8_pkg
//  Description : Shared types, widths and helpers for the 8-PAM receive slicer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pam8_pkg;

    // Receive controller states: accumulate energy, pick phase, track symbols
    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        DECIDE = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam int SYM_W = 4;
    localparam int IDX_W = 3;
    localparam int UPS   = 4;

    // Map a decision index 0..7 onto the odd PAM level 2*idx-7
    function automatic logic signed [SYM_W-1:0] idx_to_sym(input logic [IDX_W-1:0] i);
        logic [SYM_W-1:0] t;
        t = {i, 1'b1};
        return $signed(t - 4'd8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pam8_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : pam8_slicer
//  Description : Combinational 8-PAM decision: sample -> index and level.
//  Revision    : 1.0 - initial release
// ============================================================================
module pam8_slicer
    import pam8_pkg::*;
#(
    parameter int STEP_LOG2 = 8
) (
    input  logic signed [15:0]      din,
    output logic [IDX_W-1:0]        idx,
    output logic signed [SYM_W-1:0] sym
);

    // Floor-divide by two steps so thresholds fall on even multiples of STEP;
    // arithmetic shift rounds toward -inf, so a value on a threshold rounds up.
    logic signed [15:0] w_shr;
    logic signed [16:0] w_lvl;

    assign w_shr = din >>> (STEP_LOG2 + 1);
    assign w_lvl = $signed({w_shr[15], w_shr}) + 17'sd4;

    // Clamp the shifted level into the 0..7 decision range
    always_comb begin
        idx = '0;
        if (w_lvl < 17'sd0) begin
            idx = 3'd0;
        end else if (w_lvl > 17'sd7) begin
            idx = 3'd7;
        end else begin
            idx = w_lvl[2:0];
        end
    end

    assign sym = idx_to_sym(idx);

endmodule
`default_nettype wire

// File: rtl/pam8_rx_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : pam8_rx_slicer
//  Description : x4 oversampled 8-PAM receiver: per-phase energy acquisition,
//                phase selection, decimation and symbol slicing.
//  Revision    : 1.0 - initial release
// ============================================================================
module pam8_rx_slicer
    import pam8_pkg::*;
#(
    parameter int STEP_LOG2 = 8,
    parameter int ACQ_LOG2  = 6
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic signed [15:0]      din,
    input  logic                    resync,
    output logic                    locked,
    output logic [1:0]              phase,
    output logic                    sym_vld,
    output logic signed [SYM_W-1:0] sym,
    output logic [IDX_W-1:0]        idx
);

    localparam int c_ACC_W = 15 + ACQ_LOG2;
    localparam int c_CNT_W = $clog2(UPS) + ACQ_LOG2;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_pcnt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ACC_W-1:0]   r_acc [UPS];
    logic [1:0]           r_phase;
    logic                 r_sym_vld;
    logic signed [SYM_W-1:0] r_sym;
    logic [IDX_W-1:0]     r_idx;

    logic [14:0]          w_abs;
    logic [1:0]           w_best;
    logic [c_ACC_W-1:0]   w_best_val;
    logic                 w_take;
    logic [IDX_W-1:0]     w_sl_idx;
    logic signed [SYM_W-1:0] w_sl_sym;

    // |din| with the single unrepresentable magnitude saturated
    assign w_abs = (din == 16'sh8000) ? 15'h7fff :
                   (din[15] ? 15'(-din) : din[14:0]);

    // Slice only the selected phase, and never in a resync cycle
    assign w_take = (r_state == LOCK) && (r_pcnt == r_phase) && !resync;

    pam8_slicer #(
        .STEP_LOG2 (STEP_LOG2)
    ) u_slicer (
        .din (din),
        .idx (w_sl_idx),
        .sym (w_sl_sym)
    );

    // Largest accumulator wins; strict compare keeps ties on the lowest index
    always_comb begin
        w_best     = 2'd0;
        w_best_val = r_acc[0];
        for (int i = 1; i < UPS; i++) begin
            if (r_acc[i] > w_best_val) begin
                w_best     = 2'(i);
                w_best_val = r_acc[i];
            end
        end
    end

    // Next-state logic; resync overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACQ:     if (r_cnt == c_CNT_LAST) w_state_nxt = DECIDE;
            DECIDE:  w_state_nxt = LOCK;
            LOCK:    w_state_nxt = LOCK;
            default: w_state_nxt = ACQ;
        endcase
        if (resync) begin
            w_state_nxt = ACQ;
        end
    end

    // State register and free-running phase counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ACQ;
            r_pcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= r_pcnt + 2'd1;
        end
    end

    // Sample counter and per-phase energy accumulators
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
            for (int i = 0; i < UPS; i++) r_acc[i] <= '0;
        end else if (resync) begin
            r_cnt <= '0;
            for (int i = 0; i < UPS; i++) r_acc[i] <= '0;
        end else if (r_state == ACQ) begin
            r_cnt         <= r_cnt + 1'b1;
            r_acc[r_pcnt] <= r_acc[r_pcnt] + {{ACQ_LOG2{1'b0}}, w_abs};
        end
    end

    // Phase capture and registered symbol decisions
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_phase   <= 2'd0;
            r_sym_vld <= 1'b0;
            r_sym     <= '0;
            r_idx     <= '0;
        end else begin
            if (r_state == DECIDE && !resync) begin
                r_phase <= w_best;
            end
            r_sym_vld <= w_take;
            if (w_take) begin
                r_sym <= w_sl_sym;
                r_idx <= w_sl_idx;
            end
        end
    end

    assign locked  = (r_state == LOCK);
    assign phase   = r_phase;
    assign sym_vld = r_sym_vld;
    assign sym     = r_sym;
    assign idx     = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_pam8_rx_slicer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pam8_rx_slicer
//  Description : Directed self-checking bench for pam8_rx_slicer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pam8_rx_slicer;

    logic              clk;
    logic              nrst;
    logic signed [15:0] din;
    logic              resync;
    logic              locked;
    logic [1:0]        phase;
    logic              sym_vld;
    logic signed [3:0] sym;
    logic [2:0]        idx;

    int         n_cmp;
    int         n_err;
    logic [1:0] tpc;   // bench's own view of the DUT phase counter

    pam8_rx_slicer #(
        .STEP_LOG2 (8),
        .ACQ_LOG2  (6)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .din     (din),
        .resync  (resync),
        .locked  (locked),
        .phase   (phase),
        .sym_vld (sym_vld),
        .sym     (sym),
        .idx     (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, advance one clock, settle past the edge
    task automatic step(input logic signed [15:0] d);
        din = d;
        @(posedge clk);
        #1;
        tpc = tpc + 2'd1;
    endtask

    function automatic logic signed [15:0] pat(input logic [1:0] p, input logic signed [15:0] amp);
        return (tpc == p) ? amp : 16'sd0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        nrst   = 1'b0;
        resync = 1'b0;
        din    = 16'sd0;
        @(negedge clk);
        nrst = 1'b1;
        tpc  = 2'd0;
    endtask

    // Step with energy on phase p until locked; returns cycles and stray pulses
    task automatic wait_lock(input logic [1:0] p, input logic signed [15:0] amp,
                             output int n, output int spur);
        n = 0;
        spur = 0;
        while (!locked && n < 400) begin
            step(pat(p, amp));
            n++;
            if (sym_vld && !locked) spur++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; resync = 1'b0; din = 16'sd0; tpc = 2'd0;
        #2;
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0d expected 0", locked); end
        n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_cmp++; if (sym_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %0d expected 0", sym_vld); end
        n_cmp++; if (sym !== 4'sd0) begin n_err++; $display("FAIL reset_sym: got %0d expected 0", sym); end
        n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", idx); end
        @(negedge clk);
        nrst = 1'b1;
        tpc  = 2'd0;
    endtask

    task automatic test_acquire();
        int n, spur, pulses;
        logic [1:0] prev;
        apply_reset();
        wait_lock(2'd2, 16'sd1792, n, spur);
        n_cmp++; if (n !== 257) begin n_err++; $display("FAIL acq_lock_cycles: got %0d expected 257", n); end
        n_cmp++; if (spur !== 0) begin n_err++; $display("FAIL acq_stray_vld: got %0d expected 0", spur); end
        n_cmp++; if (phase !== 2'd2) begin n_err++; $display("FAIL acq_phase: got %0d expected 2", phase); end
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            step(pat(2'd2, 16'sd1792));
            prev = tpc - 2'd1;
            n_cmp++;
            if (sym_vld !== (prev == 2'd2)) begin
                n_err++; $display("FAIL acq_vld_cadence: got %0d expected %0d", sym_vld, (prev == 2'd2));
            end
            if (sym_vld) begin
                pulses++;
                n_cmp++; if (sym !== 4'sd7) begin n_err++; $display("FAIL acq_sym: got %0d expected 7", sym); end
                n_cmp++; if (idx !== 3'd7) begin n_err++; $display("FAIL acq_idx: got %0d expected 7", idx); end
            end
        end
        n_cmp++; if (pulses !== 6) begin n_err++; $display("FAIL acq_pulse_count: got %0d expected 6", pulses); end
    endtask

    task automatic test_tie();
        int n, spur, pulses;
        apply_reset();
        wait_lock(2'd0, 16'sd0, n, spur);
        n_cmp++; if (n !== 257) begin n_err++; $display("FAIL tie_lock_cycles: got %0d expected 257", n); end
        n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL tie_phase: got %0d expected 0", phase); end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(16'sd0);
            if (sym_vld) begin
                pulses++;
                n_cmp++; if (sym !== 4'sd1) begin n_err++; $display("FAIL tie_sym: got %0d expected 1", sym); end
                n_cmp++; if (idx !== 3'd4) begin n_err++; $display("FAIL tie_idx: got %0d expected 4", idx); end
            end
        end
        n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL tie_pulse_count: got %0d expected 3", pulses); end
    endtask

    // Runs while locked at phase 0 after test_tie
    task automatic test_slicer();
        logic signed [15:0] vin  [8];
        logic signed [3:0]  vsym [8];
        logic [2:0]         vidx [8];
        int pulses;
        vin  = '{16'sd0, -16'sd1, 16'sd511, 16'sd512, 16'sd1536, -16'sd1537, 16'sd32767, -16'sd32768};
        vsym = '{4'sd1, -4'sd1, 4'sd1, 4'sd3, 4'sd7, -4'sd7, 4'sd7, -4'sd7};
        vidx = '{3'd4, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd7, 3'd0};
        for (int v = 0; v < 8; v++) begin
            pulses = 0;
            for (int k = 0; k < 4; k++) begin
                step(vin[v]);
                if (sym_vld) pulses++;
            end
            n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL slice_pulses[%0d]: got %0d expected 1", vin[v], pulses); end
            n_cmp++; if (sym !== vsym[v]) begin n_err++; $display("FAIL slice_sym[%0d]: got %0d expected %0d", vin[v], sym, vsym[v]); end
            n_cmp++; if (idx !== vidx[v]) begin n_err++; $display("FAIL slice_idx[%0d]: got %0d expected %0d", vin[v], idx, vidx[v]); end
        end
    endtask

    task automatic test_resync();
        int n, spur, guard, pulses;
        logic [1:0] prev;
        apply_reset();
        wait_lock(2'd2, 16'sd1792, n, spur);
        n_cmp++; if (phase !== 2'd2) begin n_err++; $display("FAIL rsy_first_phase: got %0d expected 2", phase); end
        guard = 0;
        while (tpc != 2'd2 && guard < 4) begin
            step(pat(2'd2, 16'sd1792));
            guard++;
        end
        resync = 1'b1;
        step(pat(2'd2, 16'sd1792));
        resync = 1'b0;
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rsy_locked: got %0d expected 0", locked); end
        n_cmp++; if (sym_vld !== 1'b0) begin n_err++; $display("FAIL rsy_vld: got %0d expected 0", sym_vld); end
        wait_lock(2'd1, 16'sd1792, n, spur);
        n_cmp++; if (n !== 257) begin n_err++; $display("FAIL rsy_relock_cycles: got %0d expected 257", n); end
        n_cmp++; if (spur !== 0) begin n_err++; $display("FAIL rsy_stray_vld: got %0d expected 0", spur); end
        n_cmp++; if (phase !== 2'd1) begin n_err++; $display("FAIL rsy_phase: got %0d expected 1", phase); end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step(pat(2'd1, 16'sd1792));
            prev = tpc - 2'd1;
            n_cmp++;
            if (sym_vld !== (prev == 2'd1)) begin
                n_err++; $display("FAIL rsy_vld_cadence: got %0d expected %0d", sym_vld, (prev == 2'd1));
            end
            if (sym_vld) begin
                pulses++;
                n_cmp++; if (sym !== 4'sd7) begin n_err++; $display("FAIL rsy_sym: got %0d expected 7", sym); end
            end
        end
        n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL rsy_pulse_count: got %0d expected 2", pulses); end
    endtask

    // Runs while locked at phase 1 with sym = +7 held from test_resync
    task automatic test_reset_mid();
        int n, spur;
        resync = 1'b1;
        step(16'sd0);
        resync = 1'b0;
        for (int k = 0; k < 99; k++) step(pat(2'd3, 16'sd1792));
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL rmid_locked: got %0d expected 0", locked); end
        n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL rmid_phase: got %0d expected 0", phase); end
        n_cmp++; if (sym_vld !== 1'b0) begin n_err++; $display("FAIL rmid_vld: got %0d expected 0", sym_vld); end
        n_cmp++; if (sym !== 4'sd0) begin n_err++; $display("FAIL rmid_sym: got %0d expected 0", sym); end
        n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL rmid_idx: got %0d expected 0", idx); end
        @(negedge clk);
        nrst = 1'b1;
        tpc  = 2'd0;
        wait_lock(2'd3, 16'sd1792, n, spur);
        n_cmp++; if (n !== 257) begin n_err++; $display("FAIL rmid_relock_cycles: got %0d expected 257", n); end
        n_cmp++; if (phase !== 2'd3) begin n_err++; $display("FAIL rmid_phase_after: got %0d expected 3", phase); end
    endtask

    // Random 8-PAM, x4 zero-stuffed, triangular pulse-shaping FIR (quarter taps)
    task automatic test_e2e();
        int h [7];
        int sr [7];
        int acc, nsym, cyc, prints;
        logic [2:0] cur_idx;
        bit seen_lock;
        h = '{1, 2, 3, 4, 3, 2, 1};
        for (int k = 0; k < 7; k++) sr[k] = 0;
        cur_idx = 3'd0;
        nsym = 0; cyc = 0; prints = 0; seen_lock = 1'b0;
        apply_reset();
        while (nsym < 1000 && cyc < 5000) begin
            for (int k = 6; k > 0; k--) sr[k] = sr[k-1];
            if (tpc == 2'd0) begin
                cur_idx = 3'($urandom_range(0, 7));
                sr[0] = (2 * int'(cur_idx) - 7) * 256;
            end else begin
                sr[0] = 0;
            end
            acc = 0;
            for (int k = 0; k < 7; k++) acc += h[k] * sr[k];
            step(16'(acc / 4));
            cyc++;
            if (locked) begin
                if (!seen_lock) begin
                    seen_lock = 1'b1;
                    n_cmp++; if (phase !== 2'd3) begin n_err++; $display("FAIL e2e_phase: got %0d expected 3", phase); end
                end
                if (sym_vld) begin
                    nsym++;
                    n_cmp++;
                    if (idx !== cur_idx) begin
                        n_err++;
                        if (prints < 5) begin
                            prints++;
                            $display("FAIL e2e_idx[%0d]: got %0d expected %0d", nsym, idx, cur_idx);
                        end
                    end
                end
            end
        end
        n_cmp++; if (nsym !== 1000) begin n_err++; $display("FAIL e2e_symbol_count: got %0d expected 1000", nsym); end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        tpc    = 2'd0;
        nrst   = 1'b0;
        resync = 1'b0;
        din    = 16'sd0;
        test_reset();
        test_acquire();
        test_tie();
        test_slicer();
        test_resync();
        test_reset_mid();
        test_e2e();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
